// File: rtl/pc16_seq.sv
// pc16_seq: program counter with an optional return-address stack.
//
// Update priority each clock (rst_n_i high): clr, ret, call, load, inc, hold.
// Define PC_CALL_STACK_EN to build the return-address stack. Without it:
//  - call acts as load.
//  - ret is ignored.
//  - The stack flags are tied to "empty, no error".
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_n_i      synchronous active-low reset
//   clr_i        soft clear of the counter (stack untouched)
//   load_i       load out_o from in_i
//   in_i         jump / call target
//   inc_i        increment out_o
//   call_i       push out_o+1 and jump to in_i
//   ret_i        pop return address into out_o
//   out_o        current program counter
//   wrap_o       one-cycle pulse after an increment from all-ones
//   stk_full_o   stack holds STACK_DEPTH entries
//   stk_empty_o  stack holds no entries
//   stk_err_o    sticky overflow/underflow flag
module pc16_seq #(
    parameter int              WIDTH       = 16,
    parameter int              STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             inc_i,
    input  logic             call_i,
    input  logic             ret_i,
    output logic [WIDTH-1:0] out_o,
    output logic             wrap_o,
    output logic             stk_full_o,
    output logic             stk_empty_o,
    output logic             stk_err_o
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + WIDTH'(1);

`ifdef PC_CALL_STACK_EN
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] SP_MAX = PW'(STACK_DEPTH);

    logic [WIDTH-1:0] stk_q [STACK_DEPTH];
    logic [PW-1:0]    sp_q, sp_d;
    logic             full_q, empty_q;
    logic             err_q, err_d;
    logic             push;
    logic [AW-1:0]    wr_idx, rd_idx;

    // When the stack is full the low bits of sp_q wrap to 0, so rd_idx
    // still lands on the top entry (STACK_DEPTH-1).
    assign wr_idx = sp_q[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);

    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        sp_d   = sp_q;
        err_d  = err_q;
        push   = 1'b0;
        if (clr_i) begin
            pc_d = RESET_VAL;
        end else if (ret_i) begin
            if (sp_q == '0) begin
                err_d = 1'b1;
            end else begin
                pc_d = stk_q[rd_idx];
                sp_d = sp_q - PW'(1);
            end
        end else if (call_i) begin
            pc_d = in_i;
            if (sp_q == SP_MAX) begin
                err_d = 1'b1;
            end else begin
                push = rst_n_i;
                sp_d = sp_q + PW'(1);
            end
        end else if (load_i) begin
            pc_d = in_i;
        end else if (inc_i) begin
            pc_d   = pc_inc;
            wrap_d = &pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q    <= RESET_VAL;
            wrap_q  <= 1'b0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            full_q  <= (sp_d == SP_MAX);
            empty_q <= (sp_d == '0);
        end
    end

    // Storage needs no reset: entries above the pointer are never read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            stk_q[wr_idx] <= pc_inc;
        end
    end

    assign stk_full_o  = full_q;
    assign stk_empty_o = empty_q;
    assign stk_err_o   = err_q;
`else
    localparam int unused_depth = STACK_DEPTH;
    logic unused_ret;
    assign unused_ret = ret_i;

    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            pc_d = RESET_VAL;
        end else if (call_i || load_i) begin
            pc_d = in_i;
        end else if (inc_i) begin
            pc_d   = pc_inc;
            wrap_d = &pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q   <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign stk_full_o  = 1'b0;
    assign stk_empty_o = 1'b1;
    assign stk_err_o   = 1'b0;
`endif

    assign out_o  = pc_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_pc16_seq.sv
module tb_pc16_seq;

    logic        clk_i = 1'b0;
    logic        rst_n_i, clr_i, load_i, inc_i, call_i, ret_i;
    logic [15:0] in_i;
    logic [15:0] out_o;
    logic        wrap_o, stk_full_o, stk_empty_o, stk_err_o;

    int checks = 0;
    int errors = 0;

    pc16_seq dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clr_i       (clr_i),
        .load_i      (load_i),
        .in_i        (in_i),
        .inc_i       (inc_i),
        .call_i      (call_i),
        .ret_i       (ret_i),
        .out_o       (out_o),
        .wrap_o      (wrap_o),
        .stk_full_o  (stk_full_o),
        .stk_empty_o (stk_empty_o),
        .stk_err_o   (stk_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        clr_i = 0; load_i = 0; inc_i = 0; call_i = 0; ret_i = 0;
    endtask

    task automatic chk_flags(input string tag, input logic full, input logic empty, input logic err);
        chk({tag, "_full"},  {15'd0, stk_full_o},  {15'd0, full});
        chk({tag, "_empty"}, {15'd0, stk_empty_o}, {15'd0, empty});
        chk({tag, "_err"},   {15'd0, stk_err_o},   {15'd0, err});
    endtask

    initial begin
        idle();
        in_i = 16'h0000;
        rst_n_i = 0;
        step(); step();
        chk("rst_out", out_o, 16'h0000);
        chk("rst_wrap", {15'd0, wrap_o}, 16'd0);
        chk_flags("rst", 0, 1, 0);

        rst_n_i = 1; inc_i = 1;
        step(); chk("inc1", out_o, 16'h0001);
        step(); chk("inc2", out_o, 16'h0002);
        step(); chk("inc3", out_o, 16'h0003);
        chk("inc_wrap", {15'd0, wrap_o}, 16'd0);
        chk_flags("inc", 0, 1, 0);

        idle(); load_i = 1; in_i = 16'hFFFE;
        step(); chk("ld_fffe", out_o, 16'hFFFE);
        chk("ld_wrap", {15'd0, wrap_o}, 16'd0);
        idle(); inc_i = 1;
        step(); chk("inc_ffff", out_o, 16'hFFFF);
        chk("ffff_wrap", {15'd0, wrap_o}, 16'd0);
        step(); chk("inc_0000", out_o, 16'h0000);
        chk("wrap_pulse", {15'd0, wrap_o}, 16'd1);
        idle();
        step(); chk("hold_0000", out_o, 16'h0000);
        chk("wrap_gone", {15'd0, wrap_o}, 16'd0);

        load_i = 1; in_i = 16'h0010;
        step(); chk("ld_0010", out_o, 16'h0010);
        clr_i = 1; inc_i = 1;
        step(); chk("clr_prio", out_o, 16'h0000);
        clr_i = 0; in_i = 16'h1234;
        step(); chk("ld_over_inc", out_o, 16'h1234);
        idle();

`ifdef PC_CALL_STACK_EN
        load_i = 1; in_i = 16'h0100;
        step(); chk("ld_0100", out_o, 16'h0100);
        idle(); call_i = 1; in_i = 16'h0200;
        step(); chk("call1", out_o, 16'h0200);
        chk_flags("call1", 0, 0, 0);
        in_i = 16'h0300;
        step(); chk("call2", out_o, 16'h0300);
        idle(); ret_i = 1;
        step(); chk("ret1", out_o, 16'h0201);
        step(); chk("ret2", out_o, 16'h0101);
        chk_flags("nest_end", 0, 1, 0);

        // Stack now: 0102, then 0A01 x3 once full; fifth call overflows.
        idle(); call_i = 1; in_i = 16'h0A00;
        step(); step(); step(); step();
        chk("call4_out", out_o, 16'h0A00);
        chk_flags("call4", 1, 0, 0);
        step();
        chk("ovf_out", out_o, 16'h0A00);
        chk_flags("ovf", 1, 0, 1);
        idle(); ret_i = 1;
        step(); chk("ret_after_ovf", out_o, 16'h0A01);
        chk_flags("ret_after_ovf", 0, 0, 1);

        idle(); rst_n_i = 0;
        step(); chk_flags("rst2", 0, 1, 0);
        rst_n_i = 1; ret_i = 1;
        step(); chk("udf_out", out_o, 16'h0000);
        chk_flags("udf", 0, 1, 1);

        idle(); rst_n_i = 0;
        step(); rst_n_i = 1; load_i = 1; in_i = 16'h0007;
        step(); idle(); call_i = 1; in_i = 16'h0050;
        step(); chk("call_0050", out_o, 16'h0050);
        idle(); clr_i = 1; ret_i = 1;
        step(); chk("clr_over_ret", out_o, 16'h0000);
        chk_flags("clr_keeps_stk", 0, 0, 0);
        idle(); ret_i = 1;
        step(); chk("ret_after_clr", out_o, 16'h0008);

        idle(); call_i = 1; in_i = 16'h0060; rst_n_i = 0;
        step(); chk("rst_call_out", out_o, 16'h0000);
        chk_flags("rst_call", 0, 1, 0);
        rst_n_i = 1; in_i = 16'h0070;
        step(); chk("call_0070", out_o, 16'h0070);
        ret_i = 1; in_i = 16'h0090;
        step(); chk("ret_over_call", out_o, 16'h0001);
        chk_flags("ret_over_call", 0, 1, 0);
        idle(); load_i = 1; in_i = 16'hFFFF;
        step(); idle(); call_i = 1; in_i = 16'h0000;
        step(); chk("call_nowrap", {15'd0, wrap_o}, 16'd0);
        idle(); ret_i = 1;
        step(); chk("ret_wrapped_addr", out_o, 16'h0000);
        chk("ret_nowrap", {15'd0, wrap_o}, 16'd0);
        idle();
`else
        call_i = 1; in_i = 16'h0055;
        step(); chk("call_as_load", out_o, 16'h0055);
        chk_flags("nostk_call", 0, 1, 0);
        idle(); ret_i = 1;
        step(); chk("ret_ignored", out_o, 16'h0055);
        inc_i = 1;
        step(); chk("ret_falls_inc", out_o, 16'h0056);
        inc_i = 0; load_i = 1; in_i = 16'h0077;
        step(); chk("ret_falls_load", out_o, 16'h0077);
        idle(); ret_i = 1; call_i = 1; in_i = 16'h0099;
        step(); chk("ret_call_load", out_o, 16'h0099);
        chk_flags("nostk_end", 0, 1, 0);
        idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc16_seq.md
Name: pc16_seq

Overview:
- 16-bit program counter for the CPU datapath. Instruction memory and the jump-target path read it; it is the stateful companion to the 16-bit bitwise gate library.
- Holds the current instruction address and updates it once per clock, in priority order: clear, return, call/load, increment.
- Optionally includes a small return-address stack so the control unit can nest subroutine calls.

Parameters:
- WIDTH, 16, counter and address width in bits.
- STACK_DEPTH, 4, number of return-address stack entries (power of 2, 2..16). Used only when PC_CALL_STACK_EN is defined.
- RESET_VAL, 16'h0000, value loaded into out on reset and on clr.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- clr  input  1  synchronous soft clear of the counter. Does not clear the stack.
- load  input  1  load out from in.
- in  input  WIDTH  jump or call target.
- inc  input  1  increment out by 1.
- call  input  1  subroutine call: push return address, then jump to in.
- ret  input  1  subroutine return: pop the return address into out.
- out  output  WIDTH  current program counter, registered.
- wrap  output  1  one-cycle pulse when an increment wraps from all-ones to 0.
- stk_full  output  1  stack holds STACK_DEPTH entries.
- stk_empty  output  1  stack holds 0 entries.
- stk_err  output  1  sticky flag: overflow or underflow occurred.

Behaviour:
- Reset: one clock is decided, and reset is synchronous and active-low. When rst_n=0 at a rising edge:
  - out=RESET_VAL, wrap=0, stk_err=0.
  - Stack pointer=0, so stk_empty=1 and stk_full=0.
  - All other inputs are ignored that cycle.
- All outputs are registered. An update requested at edge N is visible on out after edge N.
- Priority each cycle with rst_n=1:
  1. clr: out=RESET_VAL. Stack is unchanged. All other requests are ignored.
  2. ret: pop. out=top entry, pointer decrements.
  3. call: push out+1 (mod 2^WIDTH), then out=in, pointer increments.
  4. load: out=in.
  5. inc: out=out+1 (mod 2^WIDTH).
  6. none of the above: out holds.
- Simultaneous call and load: call wins; the call target is the same in value.
- Simultaneous ret and call: ret wins; call is dropped (no push).
- wrap=1 for exactly the cycle after an inc-selected update where out was all-ones. Otherwise wrap=0. Calls, loads and returns never assert wrap.
- Overflow: call with stk_full=1.
  - The jump is still taken (out=in).
  - The push is dropped, the pointer is unchanged, and stk_err is set.
- Underflow: ret with stk_empty=1.
  - out holds, the pointer is unchanged, and stk_err is set.
- stk_err clears only on rst_n=0.
- Stack storage is a register array with a pointer that saturates at 0..STACK_DEPTH. It never wraps.
- Arithmetic is unsigned, WIDTH bits, and the carry-out is discarded.

Optional Feature:
- Macro: PC_CALL_STACK_EN.
- Defined: return-address stack, call/ret semantics and stack flags are implemented as described above.
- Undefined:
  - No stack storage is built.
  - call behaves exactly like load (out=in, no push).
  - ret is ignored, so priority falls through to load/inc.
  - stk_full=0, stk_empty=1 and stk_err=0, tied constant.
  - clr, load, inc and wrap behaviour is unchanged.

Test Plan:
- Reset and increment: hold rst_n=0 for 2 clocks, then inc=1 for 3 clocks. out must read 0000, then 0001, 0002, 0003. Check stk_empty=1 and wrap=0.
- Load and wrap: load=1 with in=FFFE, then inc for 2 clocks. out must read FFFE, FFFF, 0000. wrap must be 1 only in the cycle out=0000.
- Priority: with out=0010, drive clr=1, load=1, inc=1 together; out must be 0000. Then drive load=1 (in=1234) and inc=1 together; out must be 1234.
- Nested calls (macro on): from out=0100, call in=0200, then call in=0300, then ret twice. out must read 0200, 0300, 0201, 0101. stk_empty must be 1 at the end.
- Overflow and underflow (macro on, STACK_DEPTH=4):
  - 5 consecutive calls to in=0A00: out=0A00, stk_full=1, stk_err=1.
  - Reset, then ret: out holds 0000, stk_err=1.
- Mid-operation reset and macro off:
  - rst_n=0 during a call: out=0000, stack empty, stk_err=0.
  - With the macro undefined, call with in=0055 gives out=0055, and ret leaves out unchanged.
